// File: rtl/mult_ctrl_fsm_if.sv
// Handshake/strobe bundle between the multiplier control sequencer and its
// surroundings (requesting logic plus the A/B/P register datapath).
//   start_i     request a multiply (driven by the requester)
//   b_lsb_i     current LSB of register B (driven by the datapath)
//   clr_p_o     clear P
//   load_a_o    load A (multiplicand)
//   load_b_o    load B (multiplier)
//   load_p_o    P <= P + A
//   shift_o     shift the P/B pair right by one
//   unload_p_o  copy P to the product output register
//   busy_o      sequencer not idle
//   done_o      one-cycle completion pulse
// slave modport: the sequencer. master modport: requester/datapath side.
interface mult_ctrl_fsm_if;
  logic start_i;
  logic b_lsb_i;
  logic clr_p_o;
  logic load_a_o;
  logic load_b_o;
  logic load_p_o;
  logic shift_o;
  logic unload_p_o;
  logic busy_o;
  logic done_o;

  modport slave (
    input  start_i,
    input  b_lsb_i,
    output clr_p_o,
    output load_a_o,
    output load_b_o,
    output load_p_o,
    output shift_o,
    output unload_p_o,
    output busy_o,
    output done_o
  );

  modport master (
    output start_i,
    output b_lsb_i,
    input  clr_p_o,
    input  load_a_o,
    input  load_b_o,
    input  load_p_o,
    input  shift_o,
    input  unload_p_o,
    input  busy_o,
    input  done_o
  );
endinterface

// File: rtl/mult_ctrl_fsm.sv
// Control sequencer for a shift-add multiplier datapath. One start request runs
// DATA_SIZE test/[add]/shift iterations, then unloads P and pulses done.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset
//   ctrl   mult_ctrl_fsm_if.slave: start_i/b_lsb_i in; strobes, busy_o, done_o out
// Outputs are registers updated together with the state, so each one is a pure
// function of the current state and there is no input-to-output path.
module mult_ctrl_fsm #(
  parameter int unsigned DATA_SIZE = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mult_ctrl_fsm_if.slave  ctrl
);

  localparam int unsigned CNT_W = $clog2(DATA_SIZE + 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StTest,
    StAdd,
    StShift,
    StUnload,
    StDone
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      ctrl.clr_p_o    <= 1'b0;
      ctrl.load_a_o   <= 1'b0;
      ctrl.load_b_o   <= 1'b0;
      ctrl.load_p_o   <= 1'b0;
      ctrl.shift_o    <= 1'b0;
      ctrl.unload_p_o <= 1'b0;
      ctrl.busy_o     <= 1'b0;
      ctrl.done_o     <= 1'b0;
    end else begin
      // Every branch below sets the outputs belonging to the state it enters.
      ctrl.clr_p_o    <= 1'b0;
      ctrl.load_a_o   <= 1'b0;
      ctrl.load_b_o   <= 1'b0;
      ctrl.load_p_o   <= 1'b0;
      ctrl.shift_o    <= 1'b0;
      ctrl.unload_p_o <= 1'b0;
      ctrl.busy_o     <= 1'b0;
      ctrl.done_o     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ctrl.start_i) begin
            state_q      <= StClear;
            ctrl.clr_p_o <= 1'b1;
            ctrl.busy_o  <= 1'b1;
          end
        end
        StClear: begin
          state_q       <= StLoad;
          ctrl.load_a_o <= 1'b1;
          ctrl.load_b_o <= 1'b1;
          ctrl.busy_o   <= 1'b1;
        end
        StLoad: begin
          state_q     <= StTest;
          cnt_q       <= CNT_W'(DATA_SIZE);
          ctrl.busy_o <= 1'b1;
        end
        StTest: begin
          ctrl.busy_o <= 1'b1;
          if (ctrl.b_lsb_i) begin
            state_q       <= StAdd;
            ctrl.load_p_o <= 1'b1;
          end else begin
            state_q      <= StShift;
            ctrl.shift_o <= 1'b1;
          end
        end
        StAdd: begin
          state_q      <= StShift;
          ctrl.shift_o <= 1'b1;
          ctrl.busy_o  <= 1'b1;
        end
        StShift: begin
          ctrl.busy_o <= 1'b1;
          // Saturate at zero so a stray count can never wrap.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          // <= 1 rather than == 1 so a zero count still terminates the run.
          if (cnt_q <= CNT_W'(1)) begin
            state_q         <= StUnload;
            ctrl.unload_p_o <= 1'b1;
          end else begin
            state_q <= StTest;
          end
        end
        StUnload: begin
          state_q     <= StDone;
          ctrl.done_o <= 1'b1;
          ctrl.busy_o <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Directed bench for mult_ctrl_fsm: a DATA_SIZE=8 instance driving a small
// shift-add datapath model, plus a DATA_SIZE=1 instance for the minimum width.
module tb_mult_ctrl_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_ctrl_fsm_if bus ();
  mult_ctrl_fsm_if bus1 ();

  mult_ctrl_fsm #(.DATA_SIZE(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ctrl  (bus)
  );

  mult_ctrl_fsm #(.DATA_SIZE(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .ctrl  (bus1)
  );

  // Datapath model: A, B and a 9-bit P; product is {P[7:0], B} after 8 shifts.
  logic [7:0] a_in, b_in, a_q, b_q;
  logic [8:0] p_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      if (bus.clr_p_o) p_q <= '0;
      if (bus.load_a_o) a_q <= a_in;
      if (bus.load_b_o) b_q <= b_in;
      if (bus.load_p_o) p_q <= {1'b0, p_q[7:0]} + {1'b0, a_q};
      if (bus.shift_o) {p_q, b_q} <= {p_q, b_q} >> 1;
    end
  end

  assign bus.b_lsb_i = b_q[0];

  int n_checks = 0;
  int n_fail = 0;

  // Results of the last run_op call.
  int         r_done_cyc, r_shift, r_add, r_multi, r_unload, r_idle, r_extra_done;
  logic [7:0] r_mask;
  logic [15:0] r_prod;
  logic       r_busy_after;

  function automatic logic [7:0] outs_vec();
    return {bus.clr_p_o, bus.load_a_o, bus.load_b_o, bus.load_p_o,
            bus.shift_o, bus.unload_p_o, bus.busy_o, bus.done_o};
  endfunction

  // Pulse start and observe one run until done_o (cycle 1 = the cycle after the
  // start sampling edge). With poke set, start is pulsed during TEST and DONE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit poke);
    bit pend;
    bit poked;
    int n;
    pend = 0;
    poked = 0;
    a_in = a;
    b_in = b;
    r_done_cyc = -1;
    r_shift = 0;
    r_add = 0;
    r_multi = 0;
    r_unload = 0;
    r_idle = 0;
    r_extra_done = 0;
    r_mask = '0;
    r_prod = '0;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      n = int'(bus.clr_p_o) + int'(bus.load_a_o | bus.load_b_o) + int'(bus.load_p_o)
        + int'(bus.shift_o) + int'(bus.unload_p_o);
      if (n > 1 || bus.load_a_o != bus.load_b_o) r_multi++;
      if (!bus.busy_o) r_idle++;
      if (bus.load_p_o) begin
        pend = 1;
        r_add++;
      end
      if (bus.shift_o) begin
        if (pend && r_shift < 8) r_mask[r_shift[2:0]] = 1'b1;
        pend = 0;
        r_shift++;
      end
      if (bus.unload_p_o) begin
        r_unload++;
        r_prod = {p_q[7:0], b_q};
      end
      if (poke && !poked && bus.busy_o && n == 0 && !bus.done_o) begin
        bus.start_i = 1'b1;
        poked = 1;
      end
      if (bus.done_o) begin
        r_done_cyc = cyc;
        if (poke) bus.start_i = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    r_busy_after = bus.busy_o;
    repeat (5) begin
      @(negedge clk);
      if (bus.done_o) r_extra_done++;
    end
  endtask

  task automatic test_reset();
    bit seen;
    int bad;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (outs_vec() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000", outs_vec());
    end
    n_checks++;
    if ({bus1.clr_p_o, bus1.busy_o, bus1.done_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs_ds1: got %b want 000",
               {bus1.clr_p_o, bus1.busy_o, bus1.done_o});
    end
    rst = 1'b0;
    // Abort a run in the middle of SHIFT.
    a_in = 8'h21;
    b_in = 8'hFF;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.shift_o) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL reset_reach_shift: got no shift_o want shift_o within 30 cycles");
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs_vec() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async_abort: got %b want 00000000", outs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy_o || bus.unload_p_o || bus.done_o) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_no_tail: got %0d active cycles want 0", bad);
    end
    run_op(8'h12, 8'h00, 0);
    n_checks++;
    if (r_done_cyc != 20) begin
      n_fail++;
      $display("FAIL reset_rerun_done: got cycle %0d want 20", r_done_cyc);
    end
  endtask

  task automatic check_run(input string name, input int done_c, input int adds,
                           input logic [7:0] mask, input logic [15:0] prod);
    // Stimulus-level bookkeeping only; the comparisons live in the callers.
    if (0) $display("%s %0d %0d %h %h", name, done_c, adds, mask, prod);
  endtask

  task automatic test_zero();
    run_op(8'h37, 8'h00, 0);
    n_checks++;
    if (r_done_cyc != 20) begin
      n_fail++;
      $display("FAIL zero_done: got cycle %0d want 20", r_done_cyc);
    end
    n_checks++;
    if (r_shift != 8 || r_add != 0) begin
      n_fail++;
      $display("FAIL zero_counts: got shift=%0d add=%0d want 8/0", r_shift, r_add);
    end
    n_checks++;
    if (r_prod !== 16'h0000 || r_unload != 1) begin
      n_fail++;
      $display("FAIL zero_prod: got %h unload=%0d want 0000/1", r_prod, r_unload);
    end
    n_checks++;
    if (r_multi != 0 || r_idle != 0) begin
      n_fail++;
      $display("FAIL zero_strobes: got multi=%0d idle=%0d want 0/0", r_multi, r_idle);
    end
  endtask

  task automatic test_ones();
    run_op(8'hC3, 8'hFF, 0);
    n_checks++;
    if (r_done_cyc != 28) begin
      n_fail++;
      $display("FAIL ones_done: got cycle %0d want 28", r_done_cyc);
    end
    n_checks++;
    if (r_add != 8 || r_shift != 8 || r_mask !== 8'hFF) begin
      n_fail++;
      $display("FAIL ones_pattern: got add=%0d shift=%0d mask=%h want 8/8/ff",
               r_add, r_shift, r_mask);
    end
    n_checks++;
    if (r_prod !== 16'hC23D) begin
      n_fail++;
      $display("FAIL ones_prod: got %h want c23d", r_prod);
    end
    n_checks++;
    if (r_multi != 0) begin
      n_fail++;
      $display("FAIL ones_strobes: got %0d overlaps want 0", r_multi);
    end
  endtask

  task automatic test_a5();
    run_op(8'h5B, 8'hA5, 0);
    n_checks++;
    if (r_done_cyc != 24) begin
      n_fail++;
      $display("FAIL a5_done: got cycle %0d want 24", r_done_cyc);
    end
    n_checks++;
    if (r_mask !== 8'hA5 || r_add != 4) begin
      n_fail++;
      $display("FAIL a5_pattern: got mask=%h add=%0d want a5/4", r_mask, r_add);
    end
    n_checks++;
    if (r_prod !== 16'h3AA7) begin
      n_fail++;
      $display("FAIL a5_prod: got %h want 3aa7", r_prod);
    end
  endtask

  task automatic test_ignore_start();
    run_op(8'h11, 8'h0F, 1);
    n_checks++;
    if (r_done_cyc != 24) begin
      n_fail++;
      $display("FAIL ignore_done: got cycle %0d want 24", r_done_cyc);
    end
    n_checks++;
    if (r_busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy_drop: got busy=%b want 0", r_busy_after);
    end
    n_checks++;
    if (r_extra_done != 0) begin
      n_fail++;
      $display("FAIL ignore_extra_done: got %0d want 0", r_extra_done);
    end
    n_checks++;
    if (r_prod !== 16'h00FF) begin
      n_fail++;
      $display("FAIL ignore_prod: got %h want 00ff", r_prod);
    end
  endtask

  task automatic test_back_to_back();
    int dc[3];
    int nd;
    logic exp_busy;
    nd = 0;
    dc[0] = -1;
    dc[1] = -1;
    dc[2] = -1;
    a_in = 8'h07;
    b_in = 8'h03;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (nd > 0 && cyc == dc[nd-1] + 1) begin
        n_checks++;
        if (bus.busy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle_%0d: got busy=%b want 0", nd, bus.busy_o);
        end
      end
      if (nd > 0 && cyc == dc[nd-1] + 2) begin
        exp_busy = (nd < 3);
        n_checks++;
        if (bus.busy_o !== exp_busy) begin
          n_fail++;
          $display("FAIL b2b_restart_%0d: got busy=%b want %b", nd, bus.busy_o, exp_busy);
        end
      end
      if (bus.done_o && nd < 3) begin
        dc[nd] = cyc;
        nd++;
        if (nd == 3) bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    n_checks++;
    if (nd != 3 || dc[0] != 22 || dc[1] != 45 || dc[2] != 68) begin
      n_fail++;
      $display("FAIL b2b_done_cycles: got n=%0d %0d/%0d/%0d want 3 22/45/68",
               nd, dc[0], dc[1], dc[2]);
    end
  endtask

  task automatic test_size1();
    int dcyc;
    int shifts;
    int adds;
    for (int v = 0; v < 2; v++) begin
      dcyc = -1;
      shifts = 0;
      adds = 0;
      bus1.b_lsb_i = v[0];
      @(negedge clk);
      bus1.start_i = 1'b1;
      @(posedge clk);
      #1 bus1.start_i = 1'b0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
        @(negedge clk);
        if (bus1.shift_o) shifts++;
        if (bus1.load_p_o) adds++;
        if (bus1.done_o) begin
          dcyc = cyc;
          break;
        end
      end
      n_checks++;
      if (dcyc != 6 + v || shifts != 1 || adds != v) begin
        n_fail++;
        $display("FAIL size1_lsb%0d: got done=%0d shift=%0d add=%0d want %0d/1/%0d",
                 v, dcyc, shifts, adds, 6 + v, v);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in = '0;
    b_in = '0;
    bus.start_i = 1'b0;
    bus1.start_i = 1'b0;
    bus1.b_lsb_i = 1'b0;
    test_reset();
    test_zero();
    test_ones();
    test_a5();
    test_ignore_start();
    test_back_to_back();
    test_size1();
    check_run("unused", 0, 0, 8'h00, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
